alu_regfile_seq: RTL and testbench
==================================

Name: alu_regfile_seq

Overview:
Register file, flag register and command sequencer wrapped around the 8-bit combinational ALU.
- Upstream side: accepts one command at a time over a valid/ready handshake and reads the source operands.
- ALU side: drives the ALU's op, a, b and carry-in, then captures its result, carry-out and overflow.
- Downstream side: writes the result back and presents it over a second valid/ready handshake.
- Forms the operand-feed and write-back stages directly upstream and downstream of the ALU in the v1 datapath.

Parameters:
NREGS, 4, number of 8-bit registers; power of two, 2..16; AW = $clog2(NREGS).
RESET_VAL, 8'h00, reset value of every register.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_op  in  3  ALU opcode: 000 NOP, 001 LD, 010 ADD, 011 SUB, 100 NOT, 101 AND, 110 OR, 111 XOR.
cmd_dst  in  AW  destination register; also operand A.
cmd_src  in  AW  source register for operand B.
cmd_imm_sel  in  1  1: operand B = cmd_imm; 0: operand B = R[cmd_src].
cmd_imm  in  8  immediate operand.
cmd_use_c  in  1  1: ALU carry-in = C flag; 0: carry-in = 0.
alu_op  out  3  to ALU op.
alu_a  out  8  to ALU in_a.
alu_b  out  8  to ALU in_b.
alu_ci  out  1  to ALU ci.
alu_result  in  8  from ALU result.
alu_co  in  1  from ALU co.
alu_ov  in  1  from ALU ov.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_data  out  8  value written back (NOP: current R[dst]).
flags  out  4  {N,Z,V,C}, registered.

Behaviour:
- Reset (rst high at a clock edge):
  - every R[i] = RESET_VAL; flags = 0; state = IDLE.
  - res_valid = 0, res_data = 0; alu_op/alu_a/alu_b/alu_ci = 0.
  - cmd_ready = 0 while rst is high.
  - Reset wins over any operation in progress. An in-flight command is discarded with no write-back and no result handshake.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready = 1. When cmd_valid is high, latch op, dst, B operand and carry-in, with B resolved at acceptance from the imm/src selection; go to EXEC. Stay in IDLE otherwise.
  - EXEC: cmd_ready = 0. The ALU ports are driven from the latched values, registered, so the ALU inputs are stable for the whole cycle. At the end of the cycle, apply write-back and flag updates, load res_data, set res_valid = 1, go to RESP.
  - RESP: cmd_ready = 0; res_valid = 1; res_data held stable. When res_ready is high, res_valid goes to 0 on the next edge and the state returns to IDLE.
- Latency and throughput: acceptance edge to res_valid high is 2 edges. Maximum throughput is one command per 3 cycles with res_ready tied high.
- Operand rule: operand A = R[dst] as it is at acceptance. src == dst is legal.
- Write-back and flags, by op:
  - NOP: no register write; flags unchanged; res_data = R[dst].
  - LD: R[dst] = B. Z and N updated; C and V unchanged.
  - ADD/SUB: R[dst] = alu_result. C = alu_co (for SUB, C means borrow); V = alu_ov; Z and N updated.
  - NOT/AND/OR/XOR: R[dst] = alu_result. C = 0, V = 0; Z and N updated.
  - Z = (written value == 0); N = bit 7 of the written value.
- All arithmetic is 8-bit and wraps modulo 256. The 9th bit is visible only through C.
- flags and register updates become visible in the same edge that raises res_valid.

Optional Feature:
ALU_SAT_EN
- Defined: for ADD/SUB with alu_ov = 1, the written value is saturated.
  - If alu_a[7] = 0, the value is 8'h7F; otherwise 8'h80.
  - V is still set to 1; Z and N follow the saturated value; C = alu_co unchanged.
- Undefined: wrap-around only, as described in Behaviour.

Test Plan:
- Load then add: LD R0 imm 0x7F, then ADD R0 imm 0x01 (use_c = 0) -> R0 = 0x80, flags N=1 Z=0 V=1 C=0; res_data = 0x80 two edges after acceptance.
- Borrow: LD R1 0x00, then SUB R1 imm 0x01 -> R1 = 0xFF, C=1, N=1, Z=0; then ADD R2 (R2 = 0x10) imm 0x20 use_c = 1 -> R2 = 0x31, C=0.
- Logic and zero: LD R3 0xF0, AND R3 imm 0x0F -> R3 = 0x00, Z=1, C=0, V=0; NOT R3 -> 0xFF, N=1, Z=0.
- Backpressure: hold res_ready = 0 for 3 cycles after res_valid rises -> res_valid stays 1, res_data stays stable, cmd_ready stays 0, cmd_valid is ignored; res_ready = 1 -> IDLE on the next edge.
- Reset mid-op: assert rst during EXEC of ADD R0 imm 0x05 -> R0 = RESET_VAL, flags = 0, res_valid stays 0, cmd_ready = 1 in the first cycle after rst drops.
- ALU_SAT_EN defined: R0 = 0x70, ADD imm 0x20 -> R0 = 0x7F, V=1, N=0; without the macro -> R0 = 0x90, V=1, N=1.

Source files
------------

// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq
// Register file, flag register and command sequencer that sits around the
// 8-bit combinational ALU. It takes one command at a time, feeds the ALU from
// registered operand ports, writes the result back and presents it downstream.
//
// Optional feature macro: ALU_SAT_EN
//   When defined, ADD/SUB results that overflow are clamped to 8'h7F / 8'h80.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cmd_valid/cmd_ready   upstream command handshake
//   cmd_op/dst/src        opcode, destination (operand A) and source register
//   cmd_imm_sel/cmd_imm   operand B select and immediate value
//   cmd_use_c             feed the C flag into the ALU carry-in
//   alu_op/a/b/ci         registered drive to the ALU
//   alu_result/co/ov      ALU outputs sampled at the end of EXEC
//   res_valid/res_ready   downstream result handshake
//   res_data              value written back (NOP: current R[dst])
//   flags                 {N,Z,V,C}
module alu_regfile_seq #(
  parameter int          NREGS     = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         AW        = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic          cmd_imm_sel,
  input  logic [7:0]    cmd_imm,
  input  logic          cmd_use_c,
  output logic [2:0]    alu_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic          alu_ci,
  input  logic [7:0]    alu_result,
  input  logic          alu_co,
  input  logic          alu_ov,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [3:0]    flags
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    regs [NREGS];
  logic [AW-1:0] dst_q;
  logic [7:0]    wb_val;
  logic          wb_en;
  logic [3:0]    flags_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cmd_ready is suppressed combinationally during reset so nothing is
  // accepted on the reset edge even though the state still reads IDLE.
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
  end

  // Write-back value and flag update, evaluated during EXEC from the
  // registered ALU operands and the ALU's combinational outputs.
  // flags bit order: [3]=N [2]=Z [1]=V [0]=C.
  always_comb begin
    wb_val     = alu_result;
    wb_en      = 1'b1;
    flags_next = flags;
    case (alu_op)
      OP_NOP: begin
        wb_val = regs[dst_q];
        wb_en  = 1'b0;
      end
      OP_LD: begin
        wb_val = alu_b;
      end
      OP_ADD, OP_SUB: begin
        wb_val = alu_result;
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of operand A.
        if (alu_ov) wb_val = alu_a[7] ? 8'h80 : 8'h7F;
`endif
        flags_next[1] = alu_ov;
        flags_next[0] = alu_co;
      end
      default: begin
        flags_next[1:0] = 2'b00;
      end
    endcase
    if (alu_op != OP_NOP) begin
      flags_next[3] = wb_val[7];
      flags_next[2] = (wb_val == 8'h00);
    end
  end

  // Operand B and carry-in are resolved at acceptance, so later register
  // updates cannot disturb an operation already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      flags     <= 4'b0000;
      alu_op    <= 3'b000;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_ci    <= 1'b0;
      dst_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_op <= cmd_op;
            alu_a  <= regs[cmd_dst];
            alu_b  <= cmd_imm_sel ? cmd_imm : regs[cmd_src];
            alu_ci <= cmd_use_c & flags[0];
            dst_q  <= cmd_dst;
          end
        end
        EXEC: begin
          if (wb_en) regs[dst_q] <= wb_val;
          flags     <= flags_next;
          res_data  <= wb_val;
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// tb_alu_regfile_seq
// Bench for alu_regfile_seq: supplies a behavioural ALU, runs directed and
// random commands and compares results/flags with an integer reference model.
module tb_alu_regfile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src;
  logic       cmd_imm_sel;
  logic [7:0] cmd_imm;
  logic       cmd_use_c;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_ci;
  logic [7:0] alu_result;
  logic       alu_co;
  logic       alu_ov;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mregs [4];
  int mN, mZ, mV, mC;
  logic [7:0] exp_data;
  logic [3:0] exp_flags;

  always #5 clk = ~clk;

  alu_regfile_seq #(.NREGS(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_use_c(cmd_use_c),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_result(alu_result), .alu_co(alu_co), .alu_ov(alu_ov),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .flags(flags)
  );

  // Behavioural combinational ALU standing in for the real one.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum    = 9'd0;
    alu_result = 8'h00;
    alu_co     = 1'b0;
    alu_ov     = 1'b0;
    case (alu_op)
      3'd0: alu_result = alu_a;
      3'd1: alu_result = alu_b;
      3'd2: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
        alu_result = alu_sum[7:0];
        alu_co     = alu_sum[8];
        alu_ov     = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
      end
      3'd3: begin
        alu_sum    = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_ci};
        alu_result = alu_sum[7:0];
        alu_co     = alu_sum[8];
        alu_ov     = (alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_a[7]);
      end
      3'd4: alu_result = ~alu_a;
      3'd5: alu_result = alu_a & alu_b;
      3'd6: alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mN = 0; mZ = 0; mV = 0; mC = 0;
  endtask

  // Computes expected result and flags from integer arithmetic.
  task automatic modelExec(input int op, input int dst, input int b, input int use_c);
    int a, ci, t, sr, val;
    a   = mregs[dst];
    ci  = use_c ? mC : 0;
    val = a;
    case (op)
      1: val = b;
      2: begin
        t  = a + b + ci;
        val = t % 256;
        mC = (t > 255) ? 1 : 0;
        sr = toSigned(a) + toSigned(b) + ci;
        mV = (sr > 127 || sr < -128) ? 1 : 0;
      end
      3: begin
        t  = a - b - ci;
        val = (t + 512) % 256;
        mC = (t < 0) ? 1 : 0;
        sr = toSigned(a) - toSigned(b) - ci;
        mV = (sr > 127 || sr < -128) ? 1 : 0;
      end
      4: begin val = 255 - a; mC = 0; mV = 0; end
      5: begin val = a & b;   mC = 0; mV = 0; end
      6: begin val = a | b;   mC = 0; mV = 0; end
      7: begin val = a ^ b;   mC = 0; mV = 0; end
      default: ;
    endcase
`ifdef ALU_SAT_EN
    if ((op == 2 || op == 3) && mV == 1) val = (a >= 128) ? 128 : 127;
`endif
    if (op != 0) begin
      mregs[dst] = val;
      mN = (val >= 128) ? 1 : 0;
      mZ = (val == 0) ? 1 : 0;
    end
    exp_data  = 8'(val);
    exp_flags = {1'(mN), 1'(mZ), 1'(mV), 1'(mC)};
  endtask

  // Full command: accept, EXEC, optional stall in RESP, release.
  // Entered and left 1 time unit after a rising edge with the DUT in IDLE.
  task automatic applyStimulus(input int op, input int dst, input int src,
                               input int imm_sel, input int imm, input int use_c,
                               input int stall);
    int b;
    b = imm_sel ? imm : mregs[src];
    modelExec(op, dst, b, use_c);
    cmd_op      = 3'(op);
    cmd_dst     = 2'(dst);
    cmd_src     = 2'(src);
    cmd_imm_sel = 1'(imm_sel);
    cmd_imm     = 8'(imm);
    cmd_use_c   = 1'(use_c);
    cmd_valid   = 1'b1;
    res_ready   = (stall == 0);
    checkOutput("cmd_ready_idle", 8'(cmd_ready), 8'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_imm   = 8'($urandom);
    cmd_src   = 2'($urandom);
    checkOutput("res_valid_exec", 8'(res_valid), 8'd0);
    checkOutput("cmd_ready_exec", 8'(cmd_ready), 8'd0);
    @(posedge clk); #1;
    checkOutput("res_valid_resp", 8'(res_valid), 8'd1);
    checkOutput("res_data", res_data, exp_data);
    checkOutput("flags", 8'(flags), 8'(exp_flags));
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'($urandom);
      @(posedge clk); #1;
      checkOutput("stall_res_valid", 8'(res_valid), 8'd1);
      checkOutput("stall_res_data", res_data, exp_data);
      checkOutput("stall_cmd_ready", 8'(cmd_ready), 8'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("res_valid_done", 8'(res_valid), 8'd0);
    checkOutput("cmd_ready_done", 8'(cmd_ready), 8'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd0; cmd_src = 2'd0;
    cmd_imm_sel = 1'b0; cmd_imm = 8'h00; cmd_use_c = 1'b0; res_ready = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    checkOutput("rst_res_valid", 8'(res_valid), 8'd0);
    checkOutput("rst_res_data", res_data, 8'h00);
    checkOutput("rst_flags", 8'(flags), 8'h00);
    checkOutput("rst_alu_a", alu_a, 8'h00);
    checkOutput("rst_alu_op", 8'(alu_op), 8'h00);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 8'(cmd_ready), 8'd1);
    @(posedge clk); #1;

    // load then add across the signed boundary
    applyStimulus(1, 0, 0, 1, 8'h7F, 0, 0);
    applyStimulus(2, 0, 0, 1, 8'h01, 0, 0);
    // borrow then carry-in from C
    applyStimulus(1, 1, 0, 1, 8'h00, 0, 0);
    applyStimulus(3, 1, 0, 1, 8'h01, 0, 0);
    applyStimulus(1, 2, 0, 1, 8'h10, 0, 0);
    applyStimulus(2, 2, 0, 1, 8'h20, 1, 0);
    // logic ops and zero flag
    applyStimulus(1, 3, 0, 1, 8'hF0, 0, 0);
    applyStimulus(5, 3, 0, 1, 8'h0F, 0, 0);
    applyStimulus(4, 3, 0, 1, 8'h00, 0, 0);
    // register-sourced operand, src == dst, and backpressure
    applyStimulus(2, 1, 2, 0, 8'h00, 0, 3);
    applyStimulus(6, 2, 2, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 2);
    // saturation boundary
    applyStimulus(1, 0, 0, 1, 8'h70, 0, 0);
    applyStimulus(2, 0, 0, 1, 8'h20, 0, 0);

    // reset during EXEC discards the in-flight command
    cmd_op = 3'd2; cmd_dst = 2'd0; cmd_imm_sel = 1'b1; cmd_imm = 8'h05;
    cmd_use_c = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    modelReset();
    checkOutput("midrst_res_valid", 8'(res_valid), 8'd0);
    checkOutput("midrst_flags", 8'(flags), 8'h00);
    checkOutput("midrst_cmd_ready", 8'(cmd_ready), 8'd0);
    rst = 1'b0;
    #1;
    checkOutput("after_rst_cmd_ready", 8'(cmd_ready), 8'd1);
    @(posedge clk); #1;
    checkOutput("after_rst_res_valid", 8'(res_valid), 8'd0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);

    // random commands
    for (int n = 0; n < 60; n++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
    end

    // read every register back through NOP
    for (int r = 0; r < 4; r++) applyStimulus(0, r, 0, 0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
